alu_arbiter: RTL

- Shares one combinational `alu` instance between NUM_REQ requesters.
- Each requester presents a valid/ready request carrying operands A, B and a 3-bit sel opcode.
- A round-robin scheduler grants one request at a time, registers the operands into the ALU, captures the result, and returns it with the requester ID on a single response channel.
- Sits between the datapath clients (decode/execute stages, address generator) and the shared ALU.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_SEL_ADD = 3'd1;
  localparam logic [2:0] ALU_SEL_SUB = 3'd2;
  localparam logic [2:0] ALU_SEL_AND = 3'd3;
  localparam logic [2:0] ALU_SEL_OR  = 3'd4;
  localparam logic [2:0] ALU_SEL_GT  = 3'd5;
  localparam logic [2:0] ALU_SEL_EQ  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; opcodes 0 and 7 produce zero, ADD/SUB wrap with no carry out.
module alu
  import alu_pkg::*;
#(
  parameter int length = 16
) (
  input  logic [length-1:0] a,
  input  logic [length-1:0] b,
  input  logic [2:0]        sel,
  output logic [length-1:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      ALU_SEL_ADD: out = a + b;
      ALU_SEL_SUB: out = a - b;
      ALU_SEL_AND: out = a & b;
      ALU_SEL_OR:  out = a | b;
      ALU_SEL_GT:  out = {{(length-1){1'b0}}, (a > b)};
      ALU_SEL_EQ:  out = {{(length-1){1'b0}}, (a == b)};
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[IW'(idx)]) begin
        any              = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters with a single response channel.
// Optional per-requester grant counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int length  = 16,
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*length-1:0]    req_a,
  input  logic [NUM_REQ*length-1:0]    req_b,
  input  logic [NUM_REQ*3-1:0]         req_sel,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [length-1:0]            rsp_data
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic                any;
  logic [length-1:0]   op_a;
  logic [length-1:0]   op_b;
  logic [2:0]          op_sel;
  logic [length-1:0]   alu_out;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  alu #(.length(length)) u_alu (
    .a   (op_a),
    .b   (op_b),
    .sel (op_sel),
    .out (alu_out)
  );

  // Ready is offered only while idle, so at most one requester sees it.
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign next_ptr  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        // Accept stage: capture the granted payload into the ALU operand registers.
        IDLE: begin
          if (any) begin
            op_a   <= req_a[int'(gnt_idx)*length +: length];
            op_b   <= req_b[int'(gnt_idx)*length +: length];
            op_sel <= req_sel[int'(gnt_idx)*3 +: 3];
            rsp_id <= gnt_idx;
            rr_ptr <= next_ptr;
            state  <= EXEC;
          end
        end
        // Execute stage: capture the ALU result into the response register.
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        // Response stage: hold until the consumer takes it.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (stats_clr) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule
